// File: rtl/axi_lite_slave_mem_if.sv
// AXI4-Lite bundle between the DMA master and the slave memory.
// The slave modport is what the memory sees; the master modport is the DMA/bench side.
interface axi_lite_slave_mem_if;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;

  modport slave (
    input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WVALID, BREADY,
    output ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BVALID, BRESP
  );

  modport master (
    output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WVALID, BREADY,
    input  ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BVALID, BRESP
  );
endinterface

// File: rtl/axi_lite_slave_mem.sv
// Word-organised AXI4-Lite slave memory with independent read/write FSMs,
// programmable wait states, SLVERR on range/alignment faults and a backdoor preload port.
module axi_lite_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          RD_LATENCY  = 2,
  parameter int          WR_LATENCY  = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  axi_lite_slave_mem_if.slave        bus,
  input  logic                       init_en,
  input  logic [15:0]                init_addr,
  input  logic [31:0]                init_data,
  output logic [15:0]                rd_count,
  output logic [15:0]                wr_count
);
  localparam int         IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

  logic [31:0] mem [DEPTH_WORDS];
  logic        live;

  rd_state_e   r_state, r_next;
  logic [3:0]  r_cnt;
  logic [31:0] ar_addr_q, rdata_q, r_addr;
  logic [1:0]  rresp_q;
  logic        ar_take, r_sample;

  wr_state_e   w_state, w_next;
  logic [3:0]  w_cnt;
  logic        aw_got, w_got, aw_take, w_take, commit, wr_ok;
  logic [31:0] aw_addr_q, w_data_q, wr_addr, wr_data;
  logic [1:0]  bresp_q;

  // Borrow bit of a 33-bit subtraction tells us addr < BASE_ADDR.
  function automatic logic addr_ok(input logic [31:0] addr);
    logic [32:0] diff;
    diff = {1'b0, addr} - {1'b0, BASE_ADDR};
    return !diff[32] && (addr[1:0] == 2'b00) && ((diff[31:0] >> 2) < 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  // Readies are held low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) live <= 1'b0;
    else          live <= 1'b1;
  end

  // ---------------- read channel ----------------
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    r_next      = r_state;
    ar_take     = 1'b0;
    bus.ARREADY = 1'b0;
    bus.RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        bus.ARREADY = live;
        ar_take     = live && bus.ARVALID;
        if (ar_take) r_next = (RD_LATENCY == 0) ? R_RESP : R_WAIT;
      end
      R_WAIT: if (r_cnt == 4'd1) r_next = R_RESP;
      R_RESP: begin
        bus.RVALID = 1'b1;
        if (bus.RREADY) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign r_addr    = (r_state == R_IDLE) ? bus.ARADDR : ar_addr_q;
  assign r_sample  = (r_next == R_RESP) && (r_state != R_RESP);
  assign bus.RDATA = rdata_q;
  assign bus.RRESP = rresp_q;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= R_IDLE;
      r_cnt     <= 4'd0;
      ar_addr_q <= 32'h0;
      rdata_q   <= 32'h0;
      rresp_q   <= RESP_OKAY;
      rd_count  <= 16'h0;
    end else begin
      r_state <= r_next;
      if (ar_take) begin
        ar_addr_q <= bus.ARADDR;
        r_cnt     <= 4'(RD_LATENCY);
      end else if (r_state == R_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Sampling the array here returns pre-commit data on a same-edge write.
      if (r_sample) begin
        rdata_q <= addr_ok(r_addr) ? mem[addr_idx(r_addr)] : 32'h0;
        rresp_q <= addr_ok(r_addr) ? RESP_OKAY : RESP_SLVERR;
      end
      if (r_state == R_RESP && bus.RREADY) rd_count <= rd_count + 16'd1;
    end
  end

  // ---------------- write channel ----------------
  always_comb begin
    w_next      = w_state;
    aw_take     = 1'b0;
    w_take      = 1'b0;
    commit      = 1'b0;
    bus.AWREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        bus.AWREADY = live && !aw_got;
        bus.WREADY  = live && !w_got;
        aw_take     = live && !aw_got && bus.AWVALID;
        w_take      = live && !w_got && bus.WVALID;
        commit      = (aw_got || aw_take) && (w_got || w_take);
        if (commit) w_next = (WR_LATENCY == 0) ? W_RESP : W_WAIT;
      end
      W_WAIT: if (w_cnt == 4'd1) w_next = W_RESP;
      W_RESP: begin
        bus.BVALID = 1'b1;
        if (bus.BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign wr_addr   = aw_got ? aw_addr_q : bus.AWADDR;
  assign wr_data   = w_got ? w_data_q : bus.WDATA;
  assign wr_ok     = addr_ok(wr_addr);
  assign bus.BRESP = bresp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state   <= W_IDLE;
      w_cnt     <= 4'd0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= 32'h0;
      w_data_q  <= 32'h0;
      bresp_q   <= RESP_OKAY;
      wr_count  <= 16'h0;
    end else begin
      w_state <= w_next;
      if (commit) begin
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
        bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        w_cnt   <= 4'(WR_LATENCY);
      end else begin
        if (aw_take) begin
          aw_got    <= 1'b1;
          aw_addr_q <= bus.AWADDR;
        end
        if (w_take) begin
          w_got    <= 1'b1;
          w_data_q <= bus.WDATA;
        end
        if (w_state == W_WAIT) w_cnt <= w_cnt - 4'd1;
      end
      if (w_state == W_RESP && bus.BREADY) wr_count <= wr_count + 16'd1;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; contents survive reset_n.
  // The AXI write is issued last so it wins over a same-edge backdoor write.
  always_ff @(posedge clk) begin
    if (init_en)         mem[IDX_W'(init_addr)] <= init_data;
    if (commit && wr_ok) mem[addr_idx(wr_addr)] <= wr_data;
  end
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed bench for axi_lite_slave_mem: a default-latency instance for most steps
// and a zero read-latency instance for the DMA-style block copy.
`timescale 1ns/1ps
module tb_axi_lite_slave_mem;
  localparam int BUDGET = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n, sel;
  logic [31:0] araddr, awaddr, wdata, init_data;
  logic        arvalid, rready, awvalid, wvalid, bready, init_en;
  logic [15:0] init_addr;
  logic [15:0] rd_count0, wr_count0, rd_count1, wr_count1;

  axi_lite_slave_mem_if b0 ();
  axi_lite_slave_mem_if b1 ();

  assign b0.ARADDR = araddr;  assign b1.ARADDR = araddr;
  assign b0.ARVALID = arvalid; assign b1.ARVALID = arvalid;
  assign b0.RREADY = rready;  assign b1.RREADY = rready;
  assign b0.AWADDR = awaddr;  assign b1.AWADDR = awaddr;
  assign b0.AWVALID = awvalid; assign b1.AWVALID = awvalid;
  assign b0.WDATA = wdata;    assign b1.WDATA = wdata;
  assign b0.WVALID = wvalid;  assign b1.WVALID = wvalid;
  assign b0.BREADY = bready;  assign b1.BREADY = bready;

  // Observed outputs of whichever instance is under test.
  logic        arready, awready, wready, rvalid, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic [15:0] rd_count, wr_count;
  assign arready  = sel ? b1.ARREADY : b0.ARREADY;
  assign awready  = sel ? b1.AWREADY : b0.AWREADY;
  assign wready   = sel ? b1.WREADY  : b0.WREADY;
  assign rvalid   = sel ? b1.RVALID  : b0.RVALID;
  assign bvalid   = sel ? b1.BVALID  : b0.BVALID;
  assign rdata    = sel ? b1.RDATA   : b0.RDATA;
  assign rresp    = sel ? b1.RRESP   : b0.RRESP;
  assign bresp    = sel ? b1.BRESP   : b0.BRESP;
  assign rd_count = sel ? rd_count1  : rd_count0;
  assign wr_count = sel ? wr_count1  : wr_count0;

  axi_lite_slave_mem u_dut (
    .clk(clk), .reset_n(rst0_n), .bus(b0.slave),
    .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
    .rd_count(rd_count0), .wr_count(wr_count0)
  );

  axi_lite_slave_mem #(.RD_LATENCY(0)) u_dut_fast (
    .clk(clk), .reset_n(rst1_n), .bus(b1.slave),
    .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
    .rd_count(rd_count1), .wr_count(wr_count1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [15:0] idx, input logic [31:0] val);
    init_en = 1'b1; init_addr = idx; init_data = val;
    tick();
    init_en = 1'b0;
  endtask

  // Latency is counted in cycles from the AR handshake cycle to the first RVALID cycle.
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int n = 0;
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < BUDGET) begin tick(); n++; end
    check("ar_accept", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < BUDGET) begin tick(); lat++; end
    check("r_arrive", 32'(rvalid), 32'd1);
    data = rdata; resp = rresp;
    tick();
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           output logic [1:0] resp, output int lat);
    int   n = 0;
    logic aw_hs, w_hs;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    while ((awvalid || wvalid) && n < BUDGET) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick(); n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    check("aw_w_accept", 32'(awvalid || wvalid), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 1;
    while (!bvalid && lat < BUDGET) begin tick(); lat++; end
    check("b_arrive", 32'(bvalid), 32'd1);
    resp = bresp;
    tick();
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    logic        got_b, got_r;
    logic [1:0]  b_seen, r_seen;
    logic [31:0] d_seen;

    sel = 1'b0; rst0_n = 1'b0; rst1_n = 1'b0;
    araddr = '0; awaddr = '0; wdata = '0; init_data = '0; init_addr = '0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; init_en = 1'b0;
    rready = 1'b1; bready = 1'b1;
    tick();

    // Reset state
    check("rst_readies", 32'({arready, awready, wready}), 32'd0);
    check("rst_valids", 32'({rvalid, bvalid}), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resps", 32'({rresp, bresp}), 32'd0);
    check("rst_counts", {rd_count, wr_count}, 32'd0);
    rst0_n = 1'b1;
    tick();
    check("readies_after_release", 32'({arready, awready, wready}), 32'h7);

    // 1: preload and first read, RD_LATENCY=2 -> RVALID 3 cycles after handshake
    for (int i = 0; i < 4; i++) preload(16'(i), 32'h11 * 32'(i + 1));
    axi_read(32'h0, d, r, lat);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_rdata", d, 32'h11);
    check("t1_rresp", 32'(r), 32'd0);
    check("t1_rd_count", 32'(rd_count), 32'd1);

    // 2: AW in cycle 0, W in cycle 3
    awaddr = 32'h10; awvalid = 1'b1;
    check("t2_awready_c0", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("t2_awready_c%0d", c), 32'(awready), 32'd0);
      if (c < 3) tick();
    end
    wdata = 32'hDEAD_BEEF; wvalid = 1'b1;
    check("t2_wready", 32'(wready), 32'd1);
    tick();
    wvalid = 1'b0;
    check("t2_bvalid_early", 32'(bvalid), 32'd0);
    tick();
    check("t2_bvalid", 32'(bvalid), 32'd1);
    check("t2_bresp", 32'(bresp), 32'd0);
    tick();
    check("t2_bvalid_drop", 32'(bvalid), 32'd0);
    check("t2_wr_count", 32'(wr_count), 32'd1);
    axi_read(32'h10, d, r, lat);
    check("t2_readback", d, 32'hDEAD_BEEF);
    check("t2_rresp", 32'(r), 32'd0);

    // 3: out-of-range write (aliases word 0 if not blocked) and misaligned read
    awaddr = 32'h400; awvalid = 1'b1; wdata = 32'hCAFE_F00D; wvalid = 1'b1;
    araddr = 32'h2; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    got_b = 1'b0; got_r = 1'b0; b_seen = 2'b00; r_seen = 2'b00; d_seen = 32'hFFFF_FFFF;
    for (int k = 0; k < 8; k++) begin
      if (bvalid && !got_b) begin got_b = 1'b1; b_seen = bresp; end
      if (rvalid && !got_r) begin got_r = 1'b1; r_seen = rresp; d_seen = rdata; end
      tick();
    end
    check("t3_got_b", 32'(got_b), 32'd1);
    check("t3_got_r", 32'(got_r), 32'd1);
    check("t3_bresp", 32'(b_seen), 32'd2);
    check("t3_rresp", 32'(r_seen), 32'd2);
    check("t3_rdata", d_seen, 32'd0);
    check("t3_wr_count", 32'(wr_count), 32'd2);
    axi_read(32'h0, d, r, lat);
    check("t3_mem_unchanged", d, 32'h11);

    // 4: read sample and write commit to word 2 on the same edge
    araddr = 32'h8; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    awaddr = 32'h8; wdata = 32'd5; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t4_rvalid", 32'(rvalid), 32'd1);
    check("t4_old_data", rdata, 32'h33);
    tick();
    check("t4_bvalid", 32'(bvalid), 32'd1);
    tick();
    axi_read(32'h8, d, r, lat);
    check("t4_new_data", d, 32'd5);
    check("t4_rd_count", 32'(rd_count), 32'd6);

    // 5: RREADY stall for 10 cycles while a write completes
    rready = 1'b0;
    araddr = 32'hC; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    awaddr = 32'h20; wdata = 32'h1234; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      check("t5_rvalid_hold", 32'(rvalid), 32'd1);
      check("t5_rdata_hold", rdata, 32'h44);
      check("t5_arready_low", 32'(arready), 32'd0);
      tick();
    end
    check("t5_wr_count", 32'(wr_count), 32'd4);
    check("t5_bvalid_done", 32'(bvalid), 32'd0);
    rready = 1'b1;
    tick();
    check("t5_rvalid_drop", 32'(rvalid), 32'd0);
    check("t5_rd_count", 32'(rd_count), 32'd7);
    axi_read(32'h20, d, r, lat);
    check("t5_readback", d, 32'h1234);

    // 6: reset during R_WAIT with an AW-only capture pending
    araddr = 32'h0; arvalid = 1'b1; awaddr = 32'h4; awvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    #2 rst0_n = 1'b0;
    #1;
    check("t6_readies", 32'({arready, awready, wready}), 32'd0);
    check("t6_valids", 32'({rvalid, bvalid}), 32'd0);
    check("t6_rdata", rdata, 32'd0);
    check("t6_resps", 32'({rresp, bresp}), 32'd0);
    check("t6_counts", {rd_count, wr_count}, 32'd0);
    @(negedge clk);
    rst0_n = 1'b1;
    tick();
    check("t6_readies_back", 32'({arready, awready, wready}), 32'h7);
    check("t6_no_stray", 32'({rvalid, bvalid}), 32'd0);
    wdata = 32'hFFFF_FFFF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t6_no_bvalid", 32'(bvalid), 32'd0);
      tick();
    end
    axi_read(32'h4, d, r, lat);
    check("t6_mem_kept", d, 32'h22);

    // 7: DMA-style copy of 4 words 0x0 -> 0x100 on the zero-read-latency instance
    rst0_n = 1'b0; sel = 1'b1;
    rst1_n = 1'b1;
    tick();
    check("t7_readies", 32'({arready, awready, wready}), 32'h7);
    for (int i = 0; i < 4; i++) preload(16'(i), 32'h11 * 32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      axi_read(32'(4 * i), d, r, lat);
      check($sformatf("t7_rd_lat%0d", i), 32'(lat), 32'd1);
      axi_write(32'h100 + 32'(4 * i), d, r, lat);
      check($sformatf("t7_bresp%0d", i), 32'(r), 32'd0);
      check($sformatf("t7_wr_lat%0d", i), 32'(lat), 32'd2);
    end
    check("t7_rd_count", 32'(rd_count), 32'd4);
    check("t7_wr_count", 32'(wr_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      axi_read(32'h100 + 32'(4 * i), d, r, lat);
      check($sformatf("t7_dst%0d", i), d, 32'h11 * 32'(i + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/axi_lite_slave_mem.md
Name: axi_lite_slave_mem

Overview:
- Word-organised AXI4-Lite slave memory that sits directly downstream of the DMA controller.
- Serves the DMA's read traffic (AR/R) from the source region and absorbs its write traffic (AW/W/B) into the destination region.
- Read and write channels run independently, each with a programmable wait-state latency and range/alignment error responses.
- A backdoor preload port lets benches seed memory contents without AXI traffic.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- DEPTH_WORDS, 256, number of 32-bit words; power of two, max 65536.
- RD_LATENCY, 2, cycles from AR handshake to RVALID assertion; 0..15.
- WR_LATENCY, 1, cycles from write commit to BVALID assertion; 0..15.

Ports:
- clk, in, 1: single clock, all logic on the rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- ARADDR, in, 32: read byte address.
- ARVALID, in, 1: read address valid.
- ARREADY, out, 1: read address ready.
- RDATA, out, 32: read data.
- RRESP, out, 2: read response; 00 = OKAY, 10 = SLVERR.
- RVALID, out, 1: read data valid.
- RREADY, in, 1: master ready for read data.
- AWADDR, in, 32: write byte address.
- AWVALID, in, 1: write address valid.
- AWREADY, out, 1: write address ready.
- WDATA, in, 32: write data, full word (no strobes).
- WVALID, in, 1: write data valid.
- WREADY, out, 1: write data ready.
- BVALID, out, 1: write response valid.
- BREADY, in, 1: master ready for write response.
- BRESP, out, 2: write response; 00 = OKAY, 10 = SLVERR.
- init_en, in, 1: backdoor write strobe.
- init_addr, in, 16: backdoor word index.
- init_data, in, 32: backdoor data.
- rd_count, out, 16: completed R handshakes.
- wr_count, out, 16: completed B handshakes.

Behaviour:
- Reset (reset_n low, asynchronous): every output is 0, including ARREADY/AWREADY/WREADY, RDATA, RRESP, BRESP and both counters. Both FSMs go to IDLE and captured AW/W are discarded.
  - Memory contents are not reset.
  - Readies rise on the first clk edge after reset_n deasserts.
- Decode: offset = addr - BASE_ADDR.
  - Valid iff addr >= BASE_ADDR, addr[1:0] == 0, and offset>>2 < DEPTH_WORDS.
  - Word index = offset>>2, truncated to log2(DEPTH_WORDS) bits.
  - Invalid gives SLVERR; an invalid read returns RDATA = 0; an invalid write leaves memory unchanged.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: ARREADY = 1. On ARVALID & ARREADY, latch ARADDR, drive ARREADY to 0, load the latency counter with RD_LATENCY, and go to R_WAIT (RD_LATENCY = 0 goes directly to R_RESP).
  - R_WAIT: decrement the counter each cycle; at 1, go to R_RESP.
  - R_RESP: RVALID = 1. RDATA/RRESP are sampled from memory on the edge that asserts RVALID and held stable until RREADY.
  - On RVALID & RREADY: RVALID drops to 0, rd_count increments, state returns to R_IDLE, and ARREADY is 1 on the next cycle.
  - Minimum AR-to-R spacing is RD_LATENCY+1 cycles.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE: AWREADY and WREADY are independent; each is 1 until its own handshake completes, then 0.
  - AW and W may arrive in either order or in the same cycle; address and data are captured separately.
  - Commit: on the edge where both are captured, memory is written if the address is valid and BRESP is latched. Then go to W_WAIT with the counter = WR_LATENCY (0 goes to W_RESP).
  - W_WAIT: decrement the counter; at 1, go to W_RESP.
  - W_RESP: BVALID = 1 and BRESP is held until BREADY.
  - On BVALID & BREADY: BVALID drops to 0, wr_count increments, state returns to W_IDLE, and both readies are 1 on the next cycle.
- Same-edge read sample and write commit to the same word: the read returns the old data (read-before-write).
- Backdoor: init_en writes mem[init_addr mod DEPTH_WORDS] = init_data on the edge.
  - If an AXI commit occurs on the same edge to the same word, the AXI write wins.
  - Backdoor writes never touch counters or responses.
- Counters: 16-bit, wrap from FFFF to 0000.
- Master stalls: an RREADY/BREADY held low indefinitely holds the response; the other channel continues unaffected.

Test Plan:
- Preload mem[0..3] = 11,22,33,44 via init; AR 0x0, RREADY held 1, RD_LATENCY = 2 -> RVALID exactly 3 cycles after the AR handshake, RDATA = 11, RRESP = 00, rd_count = 1.
- AW 0x10 in cycle 0, W = DEADBEEF in cycle 3, BREADY = 1 -> AWREADY low cycles 1..3; BVALID asserts WR_LATENCY+1 cycles after the W handshake, BRESP = 00; a read of 0x10 returns DEADBEEF.
- AW and W in the same cycle to 0x400 (DEPTH 256), and AR 0x2 -> BRESP = 10 with memory unchanged; RRESP = 10, RDATA = 0.
- Read 0x8 and write 0x8 = 5 issued so the read sample and the write commit fall on the same edge, old value 33 -> RDATA = 33, then a subsequent read returns 5.
- Hold RREADY = 0 for 10 cycles during R_RESP -> RVALID and RDATA stable throughout, ARREADY stays 0; a concurrent write completes normally.
- Assert reset_n = 0 mid-R_WAIT and after an AW-only capture -> all outputs 0 immediately; after release there is no write to memory and no stray BVALID/RVALID, and readies are 1 after one edge.
- Full DMA-style transfer of 4 words (0x0 to 0x100) with RD_LATENCY = 0 -> mem[64..67] = 11,22,33,44, rd_count = 4, wr_count = 4.
